// File: rtl/mem_req_arbiter.sv
// Shares one AXI bridge between ICache refill, DCache refill and a one-deep DCache write buffer.
// Define ARB_FIXED_PRIO_EN for fixed DCache-first read arbitration; default is round-robin.
module mem_req_arbiter #(
    parameter int BLK_W = 128
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             ic_req,
    input  logic [31:0]      ic_addr,
    output logic             ic_gnt,
    output logic             ic_rvalid,
    output logic [BLK_W-1:0] ic_rdata,
    input  logic             dc_rreq,
    input  logic [31:0]      dc_raddr,
    output logic             dc_rgnt,
    output logic             dc_rvalid,
    output logic [BLK_W-1:0] dc_rdata,
    input  logic [3:0]       dc_wen,
    input  logic [31:0]      dc_waddr,
    input  logic [31:0]      dc_wdata,
    output logic             dc_wrdy,
    output logic             m_rreq,
    output logic [31:0]      m_raddr,
    input  logic             m_rrdy,
    input  logic             m_rvalid,
    input  logic [BLK_W-1:0] m_rdata,
    output logic [3:0]       m_wen,
    output logic [31:0]      m_waddr,
    output logic [31:0]      m_wdata,
    input  logic             m_wrdy,
    input  logic             m_wdone
);
    localparam int          OFF_W    = $clog2(BLK_W / 8);
    localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_WAIT, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {WB_EMPTY, WB_ISSUE, WB_WAIT} wb_state_t;

    rd_state_t          rd_state_q;
    wb_state_t          wb_state_q;
    logic               owner_dc_q;
    logic               ic_gnt_q, dc_rgnt_q, ic_rvalid_q, dc_rvalid_q;
    logic               m_rreq_q;
    logic [31:0]        m_raddr_q;
    logic [BLK_W-1:0]   ic_rdata_q, dc_rdata_q;
    logic [3:0]         m_wen_q;
    logic [31:0]        m_waddr_q, m_wdata_q;
    logic               dc_wrdy_q;

    logic               wb_take, wb_full, haz_valid;
    logic [31:0]        haz_addr, win_addr;
    logic               ic_elig, dc_elig, any_elig, pick_dc;

    // The hazard covers a write being accepted on this same edge, not only the buffered one.
    assign wb_full   = (wb_state_q != WB_EMPTY);
    assign wb_take   = !wb_full && (dc_wen != 4'h0);
    assign haz_valid = wb_full || wb_take;
    assign haz_addr  = wb_full ? m_waddr_q : dc_waddr;

    assign ic_elig  = ic_req  && !(haz_valid && (((ic_addr  ^ haz_addr) & ~OFF_MASK) == 32'h0));
    assign dc_elig  = dc_rreq && !(haz_valid && (((dc_raddr ^ haz_addr) & ~OFF_MASK) == 32'h0));
    assign any_elig = ic_elig || dc_elig;
    assign win_addr = pick_dc ? dc_raddr : ic_addr;

`ifdef ARB_FIXED_PRIO_EN
    assign pick_dc = dc_elig;
`else
    logic last_dc_q;  // 1 = DCache was granted last

    assign pick_dc = dc_elig && (!ic_elig || !last_dc_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_dc_q <= 1'b1;
        end else if (rd_state_q == RD_IDLE && any_elig) begin
            last_dc_q <= pick_dc;
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q  <= RD_IDLE;
            owner_dc_q  <= 1'b0;
            ic_gnt_q    <= 1'b0;
            dc_rgnt_q   <= 1'b0;
            ic_rvalid_q <= 1'b0;
            dc_rvalid_q <= 1'b0;
            m_rreq_q    <= 1'b0;
            m_raddr_q   <= 32'h0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
        end else begin
            ic_gnt_q    <= 1'b0;
            dc_rgnt_q   <= 1'b0;
            ic_rvalid_q <= 1'b0;
            dc_rvalid_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    if (any_elig) begin
                        rd_state_q <= RD_ISSUE;
                        owner_dc_q <= pick_dc;
                        ic_gnt_q   <= !pick_dc;
                        dc_rgnt_q  <= pick_dc;
                        m_rreq_q   <= 1'b1;
                        m_raddr_q  <= win_addr & ~OFF_MASK;
                    end
                end
                RD_ISSUE: begin
                    if (m_rrdy) begin
                        m_rreq_q   <= 1'b0;
                        rd_state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Only the owner's data register is written; the other keeps its last block.
                    if (m_rvalid) begin
                        rd_state_q <= RD_RESP;
                        if (owner_dc_q) begin
                            dc_rvalid_q <= 1'b1;
                            dc_rdata_q  <= m_rdata;
                        end else begin
                            ic_rvalid_q <= 1'b1;
                            ic_rdata_q  <= m_rdata;
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wb_state_q <= WB_EMPTY;
            m_wen_q    <= 4'h0;
            m_waddr_q  <= 32'h0;
            m_wdata_q  <= 32'h0;
            dc_wrdy_q  <= 1'b1;
        end else begin
            case (wb_state_q)
                WB_EMPTY: begin
                    if (wb_take) begin
                        wb_state_q <= WB_ISSUE;
                        m_wen_q    <= dc_wen;
                        m_waddr_q  <= dc_waddr;
                        m_wdata_q  <= dc_wdata;
                        dc_wrdy_q  <= 1'b0;
                    end
                end
                WB_ISSUE: begin
                    if (m_wrdy) begin
                        m_wen_q    <= 4'h0;
                        wb_state_q <= WB_WAIT;
                    end
                end
                WB_WAIT: begin
                    if (m_wdone) begin
                        wb_state_q <= WB_EMPTY;
                        dc_wrdy_q  <= 1'b1;
                    end
                end
                default: wb_state_q <= WB_EMPTY;
            endcase
        end
    end

    assign ic_gnt    = ic_gnt_q;
    assign dc_rgnt   = dc_rgnt_q;
    assign ic_rvalid = ic_rvalid_q;
    assign dc_rvalid = dc_rvalid_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;
    assign m_rreq    = m_rreq_q;
    assign m_raddr   = m_raddr_q;
    assign m_wen     = m_wen_q;
    assign m_waddr   = m_waddr_q;
    assign m_wdata   = m_wdata_q;
    assign dc_wrdy   = dc_wrdy_q;

endmodule
